// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states
// and the control-word layout driven into the datapath.
package mips_ctrl_pkg;

  localparam int OPW_DEF = 6;
  localparam int STW_DEF = 4;

  typedef logic [OPW_DEF-1:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'b000000;
  localparam opcode_t OP_LW    = 6'b100011;
  localparam opcode_t OP_SW    = 6'b101011;
  localparam opcode_t OP_BEQ   = 6'b000100;
  localparam opcode_t OP_J     = 6'b000010;
  localparam opcode_t OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STW_DEF-1:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC     = 4'd7,
    S_RCOMP    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDIEX   = 4'd11,
    S_ADDIWB   = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] aluop;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input opcode_t op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control FSM (master) and the datapath/memory side (slave).
interface multicycle_control_if #(
  parameter int OPW = 6,
  parameter int STW = 4
);
  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic           mem_req;
  logic           mem_we;
  logic           iord;
  logic           ir_write;
  logic           pc_write;
  logic           pc_write_cond;
  logic [1:0]     pc_source;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     aluop;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           reg_write;
  logic           illegal;
  logic [STW-1:0] state;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, aluop, reg_dst, mem_to_reg, reg_write, illegal, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
           alu_src_a, alu_src_b, aluop, reg_dst, mem_to_reg, reg_write, illegal, state
  );
endinterface

// File: rtl/mc_out_decode.sv
// Combinational state -> control-word decoder. Only the FETCH strobes and the
// DECODE illegal flag look past the state register.
module mc_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t  state,
  input  logic    mem_ready,
  input  opcode_t opcode,
  output ctrl_t   ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load once the instruction word has actually arrived
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALUSRCB_IMMSH;
        ctrl.aluop     = ALUOP_ADD;
        ctrl.illegal   = !op_legal(opcode);
      end
      S_MEMADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_REGB;
        ctrl.aluop     = ALUOP_FUNCT;
      end
      S_RCOMP: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_REGB;
        ctrl.aluop         = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.aluop     = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: state register and
// next-state logic; the control word comes from mc_out_decode.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  state_t         state_q;
  state_t         state_d;
  ctrl_t          ctrl;
  logic [OPW-1:0] op;

  assign op = bus.opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_IDLE:     state_d = S_FETCH;
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADDR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ADDI:       state_d = S_ADDIEX;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEMADDR: begin
        if (op == OP_LW)      state_d = S_MEMREAD;
        else if (op == OP_SW) state_d = S_MEMWRITE;
        else                  state_d = S_FETCH;
      end
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC:     state_d = S_RCOMP;
      S_RCOMP:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ADDIEX:   state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_out_decode u_out_decode (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .opcode    (op),
    .ctrl      (ctrl)
  );

  assign bus.mem_req       = ctrl.mem_req;
  assign bus.mem_we        = ctrl.mem_we;
  assign bus.iord          = ctrl.iord;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.aluop         = ctrl.aluop;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.illegal       = ctrl.illegal;
  assign bus.state         = STW'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class and
// compares the whole control word plus state every cycle against hand values.
module tb_multicycle_control;

  logic clk;
  logic rst_n;

  multicycle_control_if #(.OPW(6), .STW(4)) bus ();

  multicycle_control #(.OPW(6), .STW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {state, mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
  //  pc_source, alu_src_a, alu_src_b, aluop, reg_dst, mem_to_reg, reg_write, illegal}
  logic [20:0] cw_now;
  assign cw_now = {bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write,
                   bus.pc_write, bus.pc_write_cond, bus.pc_source, bus.alu_src_a,
                   bus.alu_src_b, bus.aluop, bus.reg_dst, bus.mem_to_reg,
                   bus.reg_write, bus.illegal};

  function automatic logic [20:0] w(input int st, input int req, input int we, input int io,
                                    input int irw, input int pcw, input int pcwc, input int pcs,
                                    input int asa, input int asb, input int aop, input int rd,
                                    input int m2r, input int rw, input int ill);
    return {st[3:0], req[0], we[0], io[0], irw[0], pcw[0], pcwc[0], pcs[1:0],
            asa[0], asb[1:0], aop[1:0], rd[0], m2r[0], rw[0], ill[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1 with inputs already driven; checks mid-cycle, then advances.
  task automatic cyc(input string tag, input logic [20:0] exp);
    #1;
    check(tag, {11'd0, cw_now}, {11'd0, exp});
    @(posedge clk);
    #1;
  endtask

  logic [20:0] W_IDLE, W_FETCH, W_FETCH_RDY, W_DECODE, W_DECODE_ILL, W_MEMADDR;
  logic [20:0] W_MEMREAD, W_MEMWB, W_MEMWRITE, W_EXEC, W_RCOMP, W_BRANCH;
  logic [20:0] W_JUMP, W_ADDIEX, W_ADDIWB;

  initial begin
    //                  st req we io irw pcw pcwc pcs asa asb aop rd m2r rw ill
    W_IDLE       = w( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    W_FETCH      = w( 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    W_FETCH_RDY  = w( 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    W_DECODE     = w( 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
    W_DECODE_ILL = w( 2, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1);
    W_MEMADDR    = w( 3, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    W_MEMREAD    = w( 4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    W_MEMWB      = w( 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    W_MEMWRITE   = w( 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    W_EXEC       = w( 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0);
    W_RCOMP      = w( 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    W_BRANCH     = w( 9, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0);
    W_JUMP       = w(10, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    W_ADDIEX     = w(11, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    W_ADDIWB     = w(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    rst_n         = 1'b0;
    bus.opcode    = 6'b000000;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset_idle", W_IDLE);
    rst_n = 1'b1;
    cyc("release_idle", W_IDLE);

    // FETCH stall, then lw with memory always ready: 5 cycles
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'b100011;
    cyc("fetch_stall", W_FETCH);
    bus.mem_ready = 1'b1;
    cyc("lw_fetch", W_FETCH_RDY);
    cyc("lw_decode", W_DECODE);
    cyc("lw_memaddr", W_MEMADDR);
    cyc("lw_memread", W_MEMREAD);
    cyc("lw_memwb", W_MEMWB);

    // sw with mem_ready low for 3 cycles in MEMWRITE
    bus.opcode = 6'b101011;
    cyc("sw_fetch", W_FETCH_RDY);
    cyc("sw_decode", W_DECODE);
    cyc("sw_memaddr", W_MEMADDR);
    bus.mem_ready = 1'b0;
    cyc("sw_wr_stall1", W_MEMWRITE);
    cyc("sw_wr_stall2", W_MEMWRITE);
    cyc("sw_wr_stall3", W_MEMWRITE);
    bus.mem_ready = 1'b1;
    cyc("sw_wr_done", W_MEMWRITE);

    // R-type; mem_ready=1 throughout, ignored outside memory states
    bus.opcode = 6'b000000;
    cyc("r_fetch", W_FETCH_RDY);
    cyc("r_decode", W_DECODE);
    cyc("r_exec", W_EXEC);
    cyc("r_rcomp", W_RCOMP);

    bus.opcode = 6'b000100;
    cyc("beq_fetch", W_FETCH_RDY);
    cyc("beq_decode", W_DECODE);
    cyc("beq_branch", W_BRANCH);

    bus.opcode = 6'b000010;
    cyc("j_fetch", W_FETCH_RDY);
    cyc("j_decode", W_DECODE);
    cyc("j_jump", W_JUMP);

    bus.opcode = 6'b001000;
    cyc("addi_fetch", W_FETCH_RDY);
    cyc("addi_decode", W_DECODE);
    cyc("addi_ex", W_ADDIEX);
    cyc("addi_wb", W_ADDIWB);

    // illegal opcode: one-cycle pulse, straight back to FETCH
    bus.opcode = 6'b111111;
    cyc("ill_fetch", W_FETCH_RDY);
    cyc("ill_decode", W_DECODE_ILL);
    bus.mem_ready = 1'b0;
    cyc("ill_after", W_FETCH);

    // lw with 2 stall cycles in MEMREAD
    bus.opcode    = 6'b100011;
    bus.mem_ready = 1'b1;
    cyc("lw2_fetch", W_FETCH_RDY);
    cyc("lw2_decode", W_DECODE);
    cyc("lw2_memaddr", W_MEMADDR);
    bus.mem_ready = 1'b0;
    cyc("lw2_rd_stall1", W_MEMREAD);
    cyc("lw2_rd_stall2", W_MEMREAD);
    bus.mem_ready = 1'b1;
    cyc("lw2_rd_done", W_MEMREAD);
    cyc("lw2_memwb", W_MEMWB);

    // asynchronous reset in the middle of a stalled MEMREAD
    cyc("lw3_fetch", W_FETCH_RDY);
    cyc("lw3_decode", W_DECODE);
    cyc("lw3_memaddr", W_MEMADDR);
    bus.mem_ready = 1'b0;
    #1;
    check("lw3_memread_req", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_word", {11'd0, cw_now}, {11'd0, W_IDLE});
    @(posedge clk);
    #1;
    cyc("rst_hold", W_IDLE);
    rst_n = 1'b1;
    cyc("rst_rel_idle", W_IDLE);
    cyc("rst_rel_fetch", W_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
